// File: rtl/tic_pkg.sv
// Shared definitions for the tic-tac-toe display pipeline.
//   - grid boundary constants (also used by the draw_square stages)
//   - board controller FSM state encoding
//   - the eight win-line masks over the 9-bit board (bit k = square k+1)
//   - small helpers used by the square decoder and the controller
package tic_pkg;

    localparam logic [11:0] COL0_X     = 12'd8;
    localparam logic [11:0] COL1_X     = 12'd344;
    localparam logic [11:0] COL2_X     = 12'd680;
    localparam logic [11:0] GRID_X_END = 12'd1015;
    localparam logic [11:0] ROW0_Y     = 12'd0;
    localparam logic [11:0] ROW1_Y     = 12'd258;
    localparam logic [11:0] ROW2_Y     = 12'd515;
    localparam logic [11:0] GRID_Y_END = 12'd767;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CHECK = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Rows, columns, then the two diagonals. Square index k = 3*row + col.
    localparam logic [7:0][8:0] WIN_MASKS = {
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    // True when the marks of one player cover any complete line.
    function automatic logic has_line(input logic [8:0] marks);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++)
            if ((marks & WIN_MASKS[i]) == WIN_MASKS[i])
                hit = 1'b1;
        return hit;
    endfunction

    // Kept as a function so a zero lower bound does not turn into a
    // constant unsigned comparison at the call site.
    function automatic logic at_least(input logic [11:0] v, input logic [11:0] lo);
        return v >= lo;
    endfunction

endpackage

// File: rtl/board_square_decode.sv
// Maps a cursor position to a board square.
//   xpos, ypos : cursor position (pixels)
//   valid      : cursor lies inside the 3x3 grid
//   idx        : square index 0..8 (3*row + col), 0 when not valid
module board_square_decode
    import tic_pkg::*;
#(
    parameter logic [11:0] C0_X  = COL0_X,
    parameter logic [11:0] C1_X  = COL1_X,
    parameter logic [11:0] C2_X  = COL2_X,
    parameter logic [11:0] X_END = GRID_X_END,
    parameter logic [11:0] R0_Y  = ROW0_Y,
    parameter logic [11:0] R1_Y  = ROW1_Y,
    parameter logic [11:0] R2_Y  = ROW2_Y,
    parameter logic [11:0] Y_END = GRID_Y_END
) (
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic        valid,
    output logic [3:0]  idx
);

    logic [1:0] col, row;
    logic       col_ok, row_ok;

    always_comb begin
        col    = 2'd0;
        row    = 2'd0;
        col_ok = 1'b1;
        row_ok = 1'b1;

        if (at_least(xpos, C0_X) && xpos < C1_X)      col = 2'd0;
        else if (at_least(xpos, C1_X) && xpos < C2_X) col = 2'd1;
        else if (at_least(xpos, C2_X) && xpos <= X_END) col = 2'd2;
        else                                          col_ok = 1'b0;

        if (at_least(ypos, R0_Y) && ypos < R1_Y)      row = 2'd0;
        else if (at_least(ypos, R1_Y) && ypos < R2_Y) row = 2'd1;
        else if (at_least(ypos, R2_Y) && ypos <= Y_END) row = 2'd2;
        else                                          row_ok = 1'b0;

        valid = col_ok & row_ok;
        idx   = valid ? ({2'b00, row} * 4'd3 + {2'b00, col}) : 4'd0;
    end

endmodule

// File: rtl/board_ctl.sv
// Tic-tac-toe game-state controller.
//   pclk, rst    : pixel clock, synchronous active-high reset
//   start_en     : game enabled; low holds the board cleared
//   xpos, ypos   : cursor position in the pclk domain
//   mouse_left   : left button level (asynchronous)
//   square_taken : bit k set when square k+1 is occupied
//   square_x     : bit k owner of square k+1 (1=X, 0=O), valid where taken
//   player_o     : side to move (0=X, 1=O)
//   win_x, win_o, draw, game_over : result flags
module board_ctl
    import tic_pkg::*;
#(
    parameter logic [11:0] C0_X  = COL0_X,
    parameter logic [11:0] C1_X  = COL1_X,
    parameter logic [11:0] C2_X  = COL2_X,
    parameter logic [11:0] X_END = GRID_X_END,
    parameter logic [11:0] R0_Y  = ROW0_Y,
    parameter logic [11:0] R1_Y  = ROW1_Y,
    parameter logic [11:0] R2_Y  = ROW2_Y,
    parameter logic [11:0] Y_END = GRID_Y_END
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        start_en,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    output logic [8:0]  square_taken,
    output logic [8:0]  square_x,
    output logic        player_o,
    output logic        win_x,
    output logic        win_o,
    output logic        draw,
    output logic        game_over
);

    logic       s1, s2, prev;
    logic       press;
    logic       valid;
    logic [3:0] idx;
    state_t     state;

    logic [8:0] mover_marks;
    logic       line;
    logic       full;
    logic       clear_all;

    board_square_decode #(
        .C0_X(C0_X), .C1_X(C1_X), .C2_X(C2_X), .X_END(X_END),
        .R0_Y(R0_Y), .R1_Y(R1_Y), .R2_Y(R2_Y), .Y_END(Y_END)
    ) u_decode (
        .xpos  (xpos),
        .ypos  (ypos),
        .valid (valid),
        .idx   (idx)
    );

    // Two-flop synchroniser plus edge detect: one pulse per button press.
    always_ff @(posedge pclk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= mouse_left;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign press = s2 & ~prev;

    // Only the side that just moved can have completed a line.
    always_comb begin
        mover_marks = player_o ? (square_taken & ~square_x) : (square_taken & square_x);
        line        = has_line(mover_marks);
        full        = &square_taken;
        clear_all   = ~start_en || (state == IDLE) || (state == OVER && press);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state        <= IDLE;
            square_taken <= '0;
            square_x     <= '0;
            player_o     <= 1'b0;
            win_x        <= 1'b0;
            win_o        <= 1'b0;
            draw         <= 1'b0;
            game_over    <= 1'b0;
        end else if (clear_all) begin
            // Disable, idle and the restart press in OVER all wipe the game;
            // the restart press never claims a square.
            state        <= start_en ? PLAY : IDLE;
            square_taken <= '0;
            square_x     <= '0;
            player_o     <= 1'b0;
            win_x        <= 1'b0;
            win_o        <= 1'b0;
            draw         <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            case (state)
                PLAY: begin
                    if (press && valid && !square_taken[idx]) begin
                        square_taken[idx] <= 1'b1;
                        square_x[idx]     <= ~player_o;
                        state             <= CHECK;
                    end
                end
                CHECK: begin
                    win_x     <= line & ~player_o;
                    win_o     <= line & player_o;
                    draw      <= full & ~line;
                    game_over <= line | full;
                    if (line || full) begin
                        state <= OVER;
                    end else begin
                        player_o <= ~player_o;
                        state    <= PLAY;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_board_ctl.sv
// Directed bench for board_ctl: a game-level model (board of marks, pending
// claim, result flags) is compared with the DUT on every falling edge, and
// literal expectations from hand-worked games pin the model.
module tb_board_ctl;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        start_en = 1'b0;
    logic [11:0] xpos = '0;
    logic [11:0] ypos = '0;
    logic        mouse_left = 1'b0;
    logic [8:0]  square_taken, square_x;
    logic        player_o, win_x, win_o, draw, game_over;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    board_ctl dut (
        .pclk        (pclk),
        .rst         (rst),
        .start_en    (start_en),
        .xpos        (xpos),
        .ypos        (ypos),
        .mouse_left  (mouse_left),
        .square_taken(square_taken),
        .square_x    (square_x),
        .player_o    (player_o),
        .win_x       (win_x),
        .win_o       (win_o),
        .draw        (draw),
        .game_over   (game_over)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- game-level model ----------------
    int mb[9];                 // 0 empty, 1 X, 2 O
    bit m_po, m_wx, m_wo, m_dr;
    bit m_en, m_chk;           // game running, claim awaiting evaluation
    bit h1, h2, h3;            // button level seen 1, 2, 3 edges ago
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic clear_model();
        for (int k = 0; k < 9; k++) mb[k] = 0;
        m_po = 0; m_wx = 0; m_wo = 0; m_dr = 0;
    endtask

    function automatic int sq_of(input int x, input int y);
        int c, r;
        if (x >= 8 && x <= 343) c = 0;
        else if (x >= 344 && x <= 679) c = 1;
        else if (x >= 680 && x <= 1015) c = 2;
        else return -1;
        if (y >= 0 && y <= 257) r = 0;
        else if (y >= 258 && y <= 514) r = 1;
        else if (y >= 515 && y <= 767) r = 2;
        else return -1;
        return 3 * r + c;
    endfunction

    always @(posedge pclk) begin
        bit press, line, full;
        int sq, mover;
        press = h2 && !h3;
        if (rst) begin
            clear_model();
            m_en = 0; m_chk = 0; h1 = 0; h2 = 0; h3 = 0;
        end else begin
            if (!start_en) begin
                clear_model(); m_en = 0; m_chk = 0;
            end else if (!m_en) begin
                m_en = 1;
            end else if (m_chk) begin
                mover = m_po ? 2 : 1;
                line = 0; full = 1;
                for (int l = 0; l < 8; l++)
                    if (mb[lines[l][0]] == mover && mb[lines[l][1]] == mover && mb[lines[l][2]] == mover)
                        line = 1;
                for (int k = 0; k < 9; k++) if (mb[k] == 0) full = 0;
                if (line) begin
                    if (mover == 1) m_wx = 1; else m_wo = 1;
                end else if (full) m_dr = 1;
                else m_po = !m_po;
                m_chk = 0;
            end else if (m_wx || m_wo || m_dr) begin
                if (press) clear_model();
            end else if (press) begin
                sq = sq_of(int'(xpos), int'(ypos));
                if (sq >= 0 && mb[sq] == 0) begin
                    mb[sq] = m_po ? 2 : 1;
                    m_chk = 1;
                end
            end
            h3 = h2; h2 = h1; h1 = mouse_left;
        end
    end

    always @(negedge pclk) begin
        logic [8:0] et, ex;
        if (cmp_en) begin
            et = '0; ex = '0;
            for (int k = 0; k < 9; k++) begin
                et[k] = (mb[k] != 0);
                ex[k] = (mb[k] == 1);
            end
            chk("model square_taken", square_taken, et);
            chk("model square_x", square_x & square_taken, ex);
            chk("model player_o", {8'b0, player_o}, {8'b0, m_po});
            chk("model win_x", {8'b0, win_x}, {8'b0, m_wx});
            chk("model win_o", {8'b0, win_o}, {8'b0, m_wo});
            chk("model draw", {8'b0, draw}, {8'b0, m_dr});
            chk("model game_over", {8'b0, game_over}, {8'b0, m_wx | m_wo | m_dr});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic click(input int x, input int y);
        xpos = 12'(x); ypos = 12'(y);
        mouse_left = 1'b1;
        tick(2);
        mouse_left = 1'b0;
        tick(4);
    endtask

    // Cursor at the middle of square k (index 0..8).
    task automatic click_sq(input int k);
        int cx[3] = '{100, 500, 800};
        int cy[3] = '{100, 400, 600};
        click(cx[k % 3], cy[k / 3]);
    endtask

    task automatic play(input int seq[9], input int n);
        for (int i = 0; i < n; i++) click_sq(seq[i]);
    endtask

    initial begin
        int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        int win9_seq[9] = '{1, 0, 2, 4, 3, 6, 5, 7, 8};
        int winx_seq[9] = '{0, 3, 1, 4, 2, 0, 0, 0, 0};

        tick(3);
        cmp_en = 1'b1;
        chk("reset square_taken", square_taken, 9'h000);
        chk("reset flags", {4'b0, player_o, win_x, win_o, draw, game_over}, 9'h000);
        rst = 1'b0;
        start_en = 1'b1;
        tick(2);

        // First claim, button held 5 cycles.
        xpos = 12'd500; ypos = 12'd600; mouse_left = 1'b1;
        tick(3);
        chk("claim taken at E2", square_taken, 9'h080);
        chk("claim owner at E2", square_x, 9'h080);
        chk("player before E3", {8'b0, player_o}, 9'h000);
        tick(1);
        chk("player after E3", {8'b0, player_o}, 9'h001);
        tick(1);
        mouse_left = 1'b0;
        tick(4);
        chk("held button one claim", square_taken, 9'h080);

        // Taken square and off-grid presses are ignored.
        click(500, 600);
        click(2, 10);
        chk("ignored taken", square_taken, 9'h080);
        chk("ignored player", {8'b0, player_o}, 9'h001);

        // One-cycle disable mid-game.
        start_en = 1'b0;
        tick(1);
        chk("disable taken", square_taken, 9'h000);
        chk("disable player", {8'b0, player_o}, 9'h000);
        start_en = 1'b1;
        tick(2);
        click(1015, 767);
        chk("corner claim", square_taken, 9'h100);
        start_en = 1'b0;
        tick(1);
        start_en = 1'b1;
        tick(2);

        // X wins on the top row.
        play(winx_seq, 5);
        chk("winx taken", square_taken, 9'h01F);
        chk("winx owner", square_x, 9'h007);
        chk("winx flags", {4'b0, player_o, win_x, win_o, draw, game_over}, 9'h009);
        click_sq(4);
        chk("restart taken", square_taken, 9'h000);
        chk("restart flags", {4'b0, player_o, win_x, win_o, draw, game_over}, 9'h000);

        // Full board, no line.
        play(draw_seq, 9);
        chk("draw taken", square_taken, 9'h1FF);
        chk("draw flags", {4'b0, player_o, win_x, win_o, draw, game_over}, 9'h003);
        click(2, 10);
        chk("draw restart", square_taken, 9'h000);

        // Line completed by the ninth claim: win, not draw.
        play(win9_seq, 9);
        chk("win9 taken", square_taken, 9'h1FF);
        chk("win9 flags", {4'b0, player_o, win_x, win_o, draw, game_over}, 9'h009);
        click_sq(0);

        // Reset while the claim is being evaluated.
        click_sq(2);
        xpos = 12'd800; ypos = 12'd400; mouse_left = 1'b1;
        tick(2);
        mouse_left = 1'b0;
        tick(1);
        chk("pre-reset claim", square_taken, 9'h024);
        rst = 1'b1;
        tick(1);
        chk("rst in check taken", square_taken, 9'h000);
        chk("rst in check flags", {4'b0, player_o, win_x, win_o, draw, game_over}, 9'h000);
        rst = 1'b0;
        tick(2);
        click_sq(3);
        chk("after reset claim", square_taken, 9'h008);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
